// File: rtl/intersection_phase_ctrl.sv
// ---------------------------------------------------------------------------
// intersection_phase_ctrl
//
// Controls the phases of a two-road intersection (main road and side road)
// and a pedestrian crossing. The main road stays green until a side-road car
// or a pedestrian request needs service. Every change of right-of-way goes
// through yellow and then an all-red clearance. Each dwell is timed by one
// shared counter that clears whenever the state changes.
//
// Light encoding per road is one-hot: RED=100, GREEN=010, YELLOW=001.
//
// Ports
//   clk         in   1  clock, rising edge
//   rst         in   1  synchronous reset, active-high
//   side_car    in   1  side-road vehicle sensor (level)
//   ped_req     in   1  pedestrian button (pulse of any width)
//   main_light  out  3  main-road light, decoded from state
//   side_light  out  3  side-road light, decoded from state
//   ped_walk    out  1  walk signal, high only while in PW
//   ped_ack     out  1  registered pulse, high on the first PW cycle
//   phase       out  3  current state code (MG=0 .. PW=6)
// ---------------------------------------------------------------------------
module intersection_phase_ctrl #(
   parameter int MG_MIN    = 8,
   parameter int Y_TIME    = 3,
   parameter int AR_TIME   = 2,
   parameter int SG_TIME   = 6,
   parameter int WALK_TIME = 5,
   parameter int TW        = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       side_car,
   input  logic       ped_req,
   output logic [2:0] main_light,
   output logic [2:0] side_light,
   output logic       ped_walk,
   output logic       ped_ack,
   output logic [2:0] phase
);

   typedef enum logic [2:0] {
      S_MG  = 3'd0,
      S_MY  = 3'd1,
      S_AR1 = 3'd2,
      S_SG  = 3'd3,
      S_SY  = 3'd4,
      S_AR2 = 3'd5,
      S_PW  = 3'd6,
      S_BAD = 3'd7
   } state_t;

   localparam logic [2:0] RED    = 3'b100;
   localparam logic [2:0] GREEN  = 3'b010;
   localparam logic [2:0] YELLOW = 3'b001;

   // A dwell of N cycles ends on the cycle in which the timer reads N-1.
   localparam logic [TW-1:0] MG_LAST   = TW'(MG_MIN - 1);
   localparam logic [TW-1:0] Y_LAST    = TW'(Y_TIME - 1);
   localparam logic [TW-1:0] AR_LAST   = TW'(AR_TIME - 1);
   localparam logic [TW-1:0] SG_LAST   = TW'(SG_TIME - 1);
   localparam logic [TW-1:0] WALK_LAST = TW'(WALK_TIME - 1);

   state_t          state_reg, state_next;
   logic [TW-1:0]   timer_reg, timer_next;
   logic            ped_pending_reg, ped_pending_next;
   logic            ped_ack_reg, ped_ack_next;
   logic            enter_pw;

   // Next-state logic
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_MG:  if (timer_reg == MG_LAST && (side_car || ped_pending_reg))
                   state_next = S_MY;
         S_MY:  if (timer_reg == Y_LAST)    state_next = S_AR1;
         // Pedestrians take priority over the side road when both are waiting.
         S_AR1: if (timer_reg == AR_LAST)   state_next = ped_pending_reg ? S_PW : S_SG;
         S_SG:  if (timer_reg == SG_LAST)   state_next = S_SY;
         S_SY:  if (timer_reg == Y_LAST)    state_next = S_AR2;
         S_AR2: if (timer_reg == AR_LAST)   state_next = S_MG;
         S_PW:  if (timer_reg == WALK_LAST) state_next = S_AR2;
         default:                           state_next = S_AR2;
      endcase
   end

   // Dwell timer: restarts on any state change. In MG it parks at MG_LAST so
   // the demand check stays armed while the main road rests on green.
   always_comb begin
      timer_next = timer_reg + 1'b1;
      if (state_next != state_reg)
         timer_next = '0;
      else if (state_reg == S_MG && timer_reg == MG_LAST)
         timer_next = timer_reg;
   end

   assign enter_pw = (state_reg == S_AR1) && (state_next == S_PW);

   // A button press in the same cycle as the clear keeps the request alive,
   // so a press during the walk entry is served on the following round.
   assign ped_pending_next = ped_req | (ped_pending_reg & ~enter_pw);
   assign ped_ack_next     = enter_pw;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg       <= S_AR2;
         timer_reg       <= '0;
         ped_pending_reg <= 1'b0;
         ped_ack_reg     <= 1'b0;
      end else begin
         state_reg       <= state_next;
         timer_reg       <= timer_next;
         ped_pending_reg <= ped_pending_next;
         ped_ack_reg     <= ped_ack_next;
      end
   end

   // Light decode from the registered state
   always_comb begin
      main_light = RED;
      side_light = RED;
      case (state_reg)
         S_MG:    main_light = GREEN;
         S_MY:    main_light = YELLOW;
         S_SG:    side_light = GREEN;
         S_SY:    side_light = YELLOW;
         default: begin
            main_light = RED;
            side_light = RED;
         end
      endcase
   end

   assign ped_walk = (state_reg == S_PW);
   assign ped_ack  = ped_ack_reg;
   assign phase    = state_reg;

endmodule

// File: tb/tb_intersection_phase_ctrl.sv
// ---------------------------------------------------------------------------
// tb_intersection_phase_ctrl
//
// Drives inputs on the falling edge and checks the outputs that the state
// shows during that cycle. The main scenarios run from a table of per-cycle
// records; walk re-request and mid-phase reset run as hand-written sequences.
// ---------------------------------------------------------------------------
module tb_intersection_phase_ctrl;

   localparam logic [2:0] P_MG = 3'd0, P_MY = 3'd1, P_AR1 = 3'd2, P_SG = 3'd3,
                          P_SY = 3'd4, P_AR2 = 3'd5, P_PW = 3'd6;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       side_car = 1'b0;
   logic       ped_req = 1'b0;
   logic [2:0] main_light, side_light, phase;
   logic       ped_walk, ped_ack;

   int tests_run = 0;
   int tests_failed = 0;
   int cyc = 0;

   typedef struct {
      logic       rst;
      logic       sc;
      logic       pr;
      logic       chk;
      logic [2:0] ph;
      logic       ack;
   } vec_t;

   vec_t vecs[$];

   intersection_phase_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .side_car   (side_car),
      .ped_req    (ped_req),
      .main_light (main_light),
      .side_light (side_light),
      .ped_walk   (ped_walk),
      .ped_ack    (ped_ack),
      .phase      (phase)
   );

   always #5 clk = ~clk;

   // Expected light codes for each phase
   function automatic logic [2:0] exp_main(input logic [2:0] ph);
      case (ph)
         P_MG:    return 3'b010;
         P_MY:    return 3'b001;
         default: return 3'b100;
      endcase
   endfunction

   function automatic logic [2:0] exp_side(input logic [2:0] ph);
      case (ph)
         P_SG:    return 3'b010;
         P_SY:    return 3'b001;
         default: return 3'b100;
      endcase
   endfunction

   task automatic push(input int n, input logic r, input logic sc, input logic pr,
                       input logic [2:0] ph, input logic ack, input logic chk);
      vec_t v;
      for (int k = 0; k < n; k++) begin
         v.rst = r; v.sc = sc; v.pr = pr; v.chk = chk; v.ph = ph; v.ack = ack;
         vecs.push_back(v);
      end
   endtask

   // One cycle: apply inputs at the falling edge, compare the outputs shown.
   task automatic step(input string name, input logic r, input logic sc, input logic pr,
                       input logic [2:0] ph, input logic ack, input logic chk);
      @(negedge clk);
      rst = r; side_car = sc; ped_req = pr;
      if (chk) begin
         tests_run++;
         $display("[TB] %s cyc %0d phase=%0d main=%b side=%b walk=%b ack=%b",
                  name, cyc, phase, main_light, side_light, ped_walk, ped_ack);
         if (phase !== ph || main_light !== exp_main(ph) || side_light !== exp_side(ph) ||
             ped_walk !== (ph == P_PW) || ped_ack !== ack) begin
            tests_failed++;
            $display("[TB] FAIL %s cyc %0d: got phase=%0d main=%b side=%b walk=%b ack=%b, want phase=%0d main=%b side=%b walk=%b ack=%b",
                     name, cyc, phase, main_light, side_light, ped_walk, ped_ack,
                     ph, exp_main(ph), exp_side(ph), ph == P_PW, ack);
         end
      end
      cyc++;
   endtask

   task automatic steps(input string name, input int n, input logic sc, input logic pr,
                        input logic [2:0] ph);
      for (int k = 0; k < n; k++) step(name, 1'b0, sc, pr, ph, 1'b0, 1'b1);
   endtask

   initial begin
      // Test 1: reset for two cycles, then all-red for two, then MG at rest
      push(1, 1, 0, 0, P_AR2, 0, 0);
      push(1, 1, 0, 0, P_AR2, 0, 1);
      push(2, 0, 0, 0, P_AR2, 0, 1);
      push(20, 0, 0, 0, P_MG, 0, 1);
      // Test 2: side car held -- full side round, then a second one with MG 8
      push(1, 0, 1, 0, P_MG, 0, 1);
      push(3, 0, 1, 0, P_MY, 0, 1);
      push(2, 0, 1, 0, P_AR1, 0, 1);
      push(6, 0, 1, 0, P_SG, 0, 1);
      push(3, 0, 1, 0, P_SY, 0, 1);
      push(2, 0, 1, 0, P_AR2, 0, 1);
      push(8, 0, 1, 0, P_MG, 0, 1);
      push(3, 0, 1, 0, P_MY, 0, 1);
      push(2, 0, 1, 0, P_AR1, 0, 1);
      push(6, 0, 1, 0, P_SG, 0, 1);
      push(3, 0, 1, 0, P_SY, 0, 1);
      push(2, 0, 1, 0, P_AR2, 0, 1);
      // Test 3: single-cycle button at MG timer 2, no side car
      push(2, 0, 0, 0, P_MG, 0, 1);
      push(1, 0, 0, 1, P_MG, 0, 1);
      push(5, 0, 0, 0, P_MG, 0, 1);
      push(3, 0, 0, 0, P_MY, 0, 1);
      push(2, 0, 0, 0, P_AR1, 0, 1);
      push(1, 0, 0, 0, P_PW, 1, 1);
      push(4, 0, 0, 0, P_PW, 0, 1);
      push(2, 0, 0, 0, P_AR2, 0, 1);
      push(12, 0, 0, 0, P_MG, 0, 1);
      // Test 4: button and side car together -- walk first, side road next round
      push(1, 0, 1, 1, P_MG, 0, 1);
      push(3, 0, 1, 0, P_MY, 0, 1);
      push(2, 0, 1, 0, P_AR1, 0, 1);
      push(1, 0, 1, 0, P_PW, 1, 1);
      push(4, 0, 1, 0, P_PW, 0, 1);
      push(2, 0, 1, 0, P_AR2, 0, 1);
      push(8, 0, 1, 0, P_MG, 0, 1);
      push(3, 0, 1, 0, P_MY, 0, 1);
      push(2, 0, 1, 0, P_AR1, 0, 1);
      push(6, 0, 1, 0, P_SG, 0, 1);
      push(3, 0, 1, 0, P_SY, 0, 1);
      push(2, 0, 1, 0, P_AR2, 0, 1);

      foreach (vecs[i])
         step("vec", vecs[i].rst, vecs[i].sc, vecs[i].pr, vecs[i].ph, vecs[i].ack, vecs[i].chk);

      // Test 5: request on the AR1->PW edge and again in PW is kept for next round
      steps("t5", 8, 0, 0, P_MG);
      steps("t5", 1, 0, 1, P_MG);              // sets pending, no exit yet
      steps("t5", 1, 0, 0, P_MG);              // pending seen at timer 7 -> exit
      steps("t5", 3, 0, 0, P_MY);
      steps("t5", 1, 0, 0, P_AR1);
      steps("t5", 1, 0, 1, P_AR1);             // press on the clearing edge
      step ("t5", 0, 0, 0, P_PW, 1, 1);
      steps("t5", 1, 0, 0, P_PW);
      steps("t5", 1, 0, 1, P_PW);              // press at PW cycle 3
      steps("t5", 2, 0, 0, P_PW);
      steps("t5", 2, 0, 0, P_AR2);
      steps("t5", 8, 0, 0, P_MG);              // exits at timer 7, no side car
      steps("t5", 3, 0, 0, P_MY);
      steps("t5", 2, 0, 0, P_AR1);
      step ("t5", 0, 0, 0, P_PW, 1, 1);
      steps("t5", 4, 0, 0, P_PW);
      steps("t5", 2, 0, 0, P_AR2);

      // Test 6: reset in the middle of SG drops the side phase and the pending walk
      steps("t6", 8, 1, 0, P_MG);
      steps("t6", 3, 1, 0, P_MY);
      steps("t6", 2, 1, 0, P_AR1);
      steps("t6", 1, 1, 0, P_SG);
      steps("t6", 1, 1, 1, P_SG);              // walk pending before the reset
      steps("t6", 1, 0, 0, P_SG);
      step ("t6", 1, 0, 0, P_SG, 0, 1);        // reset applied at SG timer 3
      steps("t6", 2, 0, 0, P_AR2);
      steps("t6", 12, 0, 0, P_MG);             // no demand survives the reset

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
